ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_pkg.sv | 32 +++
 rtl/ps2_sync_edge.sv | 37 +++
 rtl/ps2_host_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
// Contents: the FSM state encoding, default timing constants (in system clock
// cycles at 50 MHz), the idle level of the open-drain lines, and a helper used
// to size the shared cycle counter.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    localparam int DEF_INHIBIT_CYCLES = 5000;    // 100 us
    localparam int DEF_SETUP_CYCLES   = 50;      // 1 us
    localparam int DEF_TIMEOUT_CYCLES = 750000;  // 15 ms

    // Both PS/2 lines float high when nobody drives them.
    localparam logic LINE_IDLE = 1'b1;

    // Falls the host consumes while driving data, parity and stop.
    localparam logic [3:0] LAST_DRIVEN_FALL = 4'd9;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer with falling-edge detect for one raw PS/2 line.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   line         : raw asynchronous line level
//   level        : synchronized level (2-cycle latency)
//   fall         : one-cycle pulse on a 1 -> 0 transition (3-cycle latency)
module ps2_sync_edge
    import ps2_host_tx_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= LINE_IDLE;
            sync <= LINE_IDLE;
            prev <= LINE_IDLE;
            fall <= 1'b0;
        end else begin
            meta <= line;
            sync <= meta;
            prev <= sync;
            fall <= prev & ~sync;
        end
    end

    assign level = sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: sends one command byte to a keyboard using the
// host-to-device protocol (inhibit, request-to-send, 8 data bits LSB first,
// odd parity, stop, device ACK).
// Ports:
//   clock, reset            : system clock, synchronous active-high reset
//   tx_data, tx_valid       : command byte and request (taken when tx_ready)
//   tx_ready                : high only while idle
//   ps2_clk_in, ps2_data_in : raw line levels (asynchronous)
//   ps2_clk_oe, ps2_data_oe : 1 pulls the line low, 0 releases it (registered)
//   tx_done                 : one-cycle pulse, byte sent and ACK seen
//   tx_error                : one-cycle pulse, timeout or missing ACK
//   tx_busy                 : high whenever not idle
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_error,
    output logic       tx_busy
);

    localparam int CNT_W = $clog2(max3(INHIBIT_CYCLES, SETUP_CYCLES, TIMEOUT_CYCLES) + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       shift;      // {stop, parity, data}; shifts right, fills with 1
    logic             ack_ok;
    logic             clk_level;
    logic             clk_fall;
    logic             data_level;
    logic             data_fall_unused;
    logic             accept;
    logic             watchdog;
    logic             timeout;
    logic             bus_idle;
    logic             clk_oe_d;
    logic             data_oe_d;
    logic             done_d;
    logic             error_d;

    ps2_sync_edge u_clk_sync (
        .clock (clock),
        .reset (reset),
        .line  (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    // Only the level of the data line matters; its edges are not used.
    ps2_sync_edge u_data_sync (
        .clock (clock),
        .reset (reset),
        .line  (ps2_data_in),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    assign accept   = (state == IDLE) && tx_valid && tx_ready;
    // The shared counter doubles as a per-fall watchdog once the device clocks.
    assign watchdog = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
    assign timeout  = watchdog && !clk_fall && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_idle = clk_level && data_level;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; falls during INHIBIT/REQ are device contention and ignored
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (accept) state_next = INHIBIT;
            INHIBIT:   if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) state_next = REQ;
            REQ:       if (cnt == CNT_W'(SETUP_CYCLES - 1)) state_next = SEND;
            SEND: begin
                if (clk_fall && bit_cnt == LAST_DRIVEN_FALL) state_next = ACK;
                else if (timeout)                           state_next = IDLE;
            end
            ACK: begin
                if (clk_fall)     state_next = WAIT_IDLE;
                else if (timeout) state_next = IDLE;
            end
            WAIT_IDLE: begin
                if (bus_idle)     state_next = IDLE;
                else if (timeout) state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered bus and status outputs
    always_comb begin
        clk_oe_d  = (state_next == INHIBIT) || (state_next == REQ);
        data_oe_d = 1'b0;
        if (state_next == REQ) begin
            data_oe_d = 1'b1;
        end else if (state_next == SEND) begin
            if (state != SEND)  data_oe_d = 1'b1;       // start bit held over from REQ
            else if (clk_fall)  data_oe_d = ~shift[0];
            else                data_oe_d = ps2_data_oe;
        end
        done_d  = (state == WAIT_IDLE) && bus_idle && ack_ok;
        // A bus that goes idle on the watchdog's last cycle still counts as a clean finish.
        error_d = (timeout && !((state == WAIT_IDLE) && bus_idle))
                  || ((state == ACK) && clk_fall && data_level);
    end

    // Output registers and datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            tx_busy     <= 1'b0;
            tx_ready    <= 1'b0;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '1;
            ack_ok      <= 1'b0;
        end else begin
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            tx_done     <= done_d;
            tx_error    <= error_d;
            tx_busy     <= (state_next != IDLE);
            tx_ready    <= (state_next == IDLE);

            if ((state_next != state) || (state_next == IDLE)) begin
                cnt <= '0;
            end else if (watchdog && clk_fall) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (accept) begin
                shift   <= {1'b1, ~^tx_data, tx_data};
                bit_cnt <= '0;
                ack_ok  <= 1'b0;
            end else if ((state == SEND) && clk_fall) begin
                shift   <= {1'b1, shift[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end

            if ((state == ACK) && clk_fall) begin
                ack_ok <= ~data_level;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard on the open-drain bus, a
// scoreboard of expected outcomes per request, and monitors for the bus
// timing and the done/error pulses.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 5000;
    localparam int SETUP   = 50;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 20;     // keyboard half clock period, in system cycles

    typedef enum int {K_DONE, K_NACK, K_TIMEOUT} kind_t;
    typedef struct {
        logic [7:0] data;
        kind_t      kind;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_done;
    logic       tx_error;
    logic       tx_busy;

    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       dev_ack = 1'b1;
    int         dev_stop = 0;
    int         dev_falls = 0;
    logic       abort = 1'b0;
    int         cyc = 0;
    int         last_fall_cyc = 0;

    exp_t       exp_q[$];
    logic [9:0] rx_q[$];

    int checks = 0;
    int passes = 0;

    // Wired-AND open-drain bus
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .tx_busy     (tx_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Frame as the keyboard should see it: data LSB first, odd parity, stop = 1
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        repeat (95000) @(posedge clock);
        $display("FAIL global_timeout: cycle %0d, expected finish before 95000", cyc);
        $fatal(1, "bench stopped");
    end

    // Keyboard: waits for inhibit + request-to-send, then clocks 11 falls
    initial begin
        logic [9:0] frame;
        logic       quit;
        frame = '1;
        forever begin
            @(posedge clock);
            if (!abort && ps2_clk_in == 1'b0) begin
                while (!abort && !(ps2_clk_in == 1'b1 && ps2_data_in == 1'b0)) @(posedge clock);
                dev_falls = 0;
                quit = abort;
                for (int i = 1; i <= 11; i++) begin
                    if (quit) break;
                    if (i == 11) dev_data = dev_ack ? 1'b0 : 1'b1;
                    repeat (HALF) @(posedge clock);
                    if (abort) begin
                        quit = 1'b1;
                        break;
                    end
                    dev_clk = 1'b0;
                    dev_falls = i;
                    last_fall_cyc = cyc;
                    repeat (HALF) @(posedge clock);
                    if (i <= 10) frame[i-1] = ps2_data_in;
                    if (i == 10 && !abort) rx_q.push_back(frame);
                    dev_clk = 1'b1;
                    if (i == dev_stop || abort) quit = 1'b1;
                end
                dev_clk = 1'b1;
                repeat (HALF) @(posedge clock);
                dev_data = 1'b1;
                while (abort) @(posedge clock);
            end
        end
    end

    // Inhibit and setup durations, measured on the oe outputs
    initial begin
        int inh_run;
        int set_run;
        inh_run = 0;
        set_run = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                inh_run = 0;
                set_run = 0;
            end else if (ps2_clk_oe && !ps2_data_oe) begin
                inh_run++;
            end else if (ps2_clk_oe && ps2_data_oe) begin
                if (inh_run != 0) chk("inhibit_len", 32'(inh_run), 32'(INHIBIT));
                inh_run = 0;
                set_run++;
            end else begin
                if (set_run != 0) chk("setup_len", 32'(set_run), 32'(SETUP));
                inh_run = 0;
                set_run = 0;
            end
        end
    end

    // Scoreboard monitor: one expected outcome per done/error pulse
    initial begin
        exp_t       e;
        logic [9:0] f;
        logic [9:0] ef;
        int         lat;
        forever begin
            @(negedge clock);
            if (tx_done || tx_error) begin
                chk("done_error_exclusive", 32'(tx_done & tx_error), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'({tx_done, tx_error}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_pulse", 32'(tx_done), 32'(e.kind == K_DONE));
                    chk("error_pulse", 32'(tx_error), 32'(e.kind != K_DONE));
                    chk("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
                    chk("ready_at_pulse", 32'(tx_ready), 32'(e.kind != K_NACK));
                    if (e.kind == K_TIMEOUT) begin
                        lat = cyc - last_fall_cyc;
                        chk("timeout_latency_window", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 6), 32'd1);
                    end else if (rx_q.size() == 0) begin
                        chk("frame_present", 32'(rx_q.size()), 32'd1);
                    end else begin
                        f  = rx_q.pop_front();
                        ef = model_frame(e.data);
                        chk("data_bits", 32'(f[7:0]), 32'(ef[7:0]));
                        chk("parity_bit", 32'(f[8]), 32'(ef[8]));
                        chk("stop_bit", 32'(f[9]), 32'(ef[9]));
                    end
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 12000) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (4 * HALF) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] d, input logic ack, input int stop_after);
        exp_t e;
        int   n;
        dev_ack  = ack;
        dev_stop = stop_after;
        e.data = d;
        e.kind = (stop_after != 0) ? K_TIMEOUT : (ack ? K_DONE : K_NACK);
        n = 0;
        @(negedge clock);
        while (!tx_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("ready_before_send", 32'(tx_ready), 32'd1);
        exp_q.push_back(e);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        wait_drain("transfer_completes");
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("reset_done", 32'(tx_done), 32'd0);
        chk("reset_error", 32'(tx_error), 32'd0);
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_ready", 32'(tx_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("ready_after_reset", 32'(tx_ready), 32'd1);

        send(8'hED, 1'b1, 0);
        send(8'hF4, 1'b1, 0);
        send(8'h00, 1'b0, 0);
        send(8'($urandom), 1'b1, 4);

        // Reset during fall 6 of 0xAA
        dev_ack  = 1'b1;
        dev_stop = 0;
        @(negedge clock);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        n = 0;
        while (dev_falls != 6 && n < 10000) begin
            @(negedge clock);
            n++;
        end
        chk("reached_fall6", 32'(dev_falls), 32'd6);
        abort = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midreset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("midreset_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("midreset_pulses", 32'({tx_done, tx_error}), 32'd0);
        repeat (2) @(negedge clock);
        chk("midreset_ready", 32'(tx_ready), 32'd0);
        chk("midreset_busy", 32'(tx_busy), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("ready_after_midreset", 32'(tx_ready), 32'd1);
        repeat (3 * HALF) @(negedge clock);
        abort = 1'b0;
        send(8'hFF, 1'b1, 0);

        // tx_valid held through two transfers
        begin
            exp_t e;
            dev_ack  = 1'b1;
            dev_stop = 0;
            @(negedge clock);
            e.data = 8'hED;
            e.kind = K_DONE;
            exp_q.push_back(e);
            tx_data  = 8'hED;
            tx_valid = 1'b1;
            n = 0;
            while (!tx_busy && n < 100) begin
                @(negedge clock);
                n++;
            end
            chk("b2b_first_accept", 32'(tx_busy), 32'd1);
            tx_data = 8'h02;
            e.data  = 8'h02;
            exp_q.push_back(e);
            n = 0;
            while (tx_busy && n < 12000) begin
                @(negedge clock);
                n++;
            end
            n = 0;
            while (!tx_busy && n < 100) begin
                @(negedge clock);
                n++;
            end
            chk("b2b_idle_cycles", 32'(n), 32'd1);
            tx_valid = 1'b0;
            wait_drain("b2b_completes");
            repeat (200) @(negedge clock);
            chk("b2b_no_extra_transfer", 32'(tx_busy), 32'd0);
        end

        for (int k = 0; k < 3; k++) send(8'($urandom), 1'b1, 0);

        chk("leftover_frames", 32'(rx_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
